// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// It sits between the MEM stage and a word-aligned req/ack data memory port.
// Legal load hits are answered in the same cycle. Load misses and all stores
// stall the pipeline until memory acknowledges, then spend one RESP cycle.
module dcache_wt #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [DATA_WIDTH-1:0] i_cpu_addr,
    input  logic [2:0]            i_cpu_ctrl,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_stall,
    output logic                  o_misalign,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [3:0]            o_mem_be,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_ack
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = DATA_WIDTH - IDX - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_RESP
    } state_t;

    // Size 00 byte, 01 half, 10 word; 11 is never legal.
    function automatic logic is_illegal(input logic [2:0] ctrl, input logic [1:0] off);
        case (ctrl[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    // Pick the addressed byte/half out of a word and extend it; ctrl[2] selects zero-extension.
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] word,
                                                      input logic [1:0] off,
                                                      input logic [2:0] ctrl);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (ctrl[1:0])
            2'b00:   return {{24{b[7] & ~ctrl[2]}}, b};
            2'b01:   return {{16{h[15] & ~ctrl[2]}}, h};
            2'b10:   return word;
            default: return '0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] ctrl, input logic [1:0] off);
        case (ctrl[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Store data is replicated across lanes so memory only needs the byte enables.
    function automatic logic [DATA_WIDTH-1:0] replicate(input logic [2:0] ctrl,
                                                        input logic [DATA_WIDTH-1:0] wdata);
        case (ctrl[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    state_t                  r_state;
    state_t                  w_next;
    logic [SETS-1:0]         r_valid;
    logic [TAG_W-1:0]        r_tags [SETS];
    logic [DATA_WIDTH-1:0]   r_data [SETS];
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [2:0]              r_ctrl;
    logic [DATA_WIDTH-1:0]   r_resp;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [DATA_WIDTH-1:0]   r_mem_addr;
    logic [3:0]              r_mem_be;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;

    logic [1:0]              w_off;
    logic [IDX-1:0]          w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_illegal;
    logic                    w_hit;
    logic [IDX-1:0]          w_ridx;
    logic [TAG_W-1:0]        w_rtag;
    logic                    w_rhit;
    logic                    w_fill;
    logic                    w_merge;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_stall;
    logic [DATA_WIDTH-1:0]   w_rdata;

    // Live request decode (IDLE) and latched request decode (wait states).
    assign w_off     = i_cpu_addr[1:0];
    assign w_idx     = i_cpu_addr[IDX+1:2];
    assign w_tag     = i_cpu_addr[DATA_WIDTH-1:IDX+2];
    assign w_illegal = is_illegal(i_cpu_ctrl, w_off);
    assign w_hit     = r_valid[w_idx] && (r_tags[w_idx] == w_tag);

    assign w_ridx    = r_addr[IDX+1:2];
    assign w_rtag    = r_addr[DATA_WIDTH-1:IDX+2];
    assign w_rhit    = r_valid[w_ridx] && (r_tags[w_ridx] == w_rtag);

    assign w_fill    = (r_state == S_RD_WAIT) && i_mem_ack;
    assign w_merge   = (r_state == S_WR_WAIT) && i_mem_ack && w_rhit;

    // Cached word with the store's enabled bytes overlaid.
    always_comb begin
        w_merged = r_data[w_ridx];
        for (int i = 0; i < 4; i++) begin
            if (r_mem_be[i]) w_merged[8*i +: 8] = r_mem_wdata[8*i +: 8];
        end
    end

    // Next-state and CPU-facing outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        w_next  = r_state;
        w_stall = 1'b0;
        w_rdata = '0;
        case (r_state)
            S_IDLE: begin
                if (i_cpu_req && !w_illegal) begin
                    if (i_cpu_we) begin
                        w_stall = 1'b1;
                        w_next  = S_WR_WAIT;
                    end else if (w_hit) begin
                        w_rdata = extract(r_data[w_idx], w_off, i_cpu_ctrl);
                    end else begin
                        w_stall = 1'b1;
                        w_next  = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT, S_WR_WAIT: begin
                w_stall = 1'b1;
                if (i_mem_ack) w_next = S_RESP;
            end
            default: begin
                w_rdata = r_resp;
                w_next  = S_IDLE;
            end
        endcase
    end

    // State, valid bits, latched request and registered memory port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_addr      <= '0;
            r_ctrl      <= '0;
            r_resp      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_next != S_IDLE) begin
                        r_addr     <= i_cpu_addr;
                        r_ctrl     <= i_cpu_ctrl;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= i_cpu_we;
                        r_mem_addr <= {i_cpu_addr[DATA_WIDTH-1:2], 2'b00};
                        r_mem_be   <= i_cpu_we ? byte_en(i_cpu_ctrl, w_off) : 4'b0000;
                        if (i_cpu_we) r_mem_wdata <= replicate(i_cpu_ctrl, i_cpu_wdata);
                    end
                end
                S_RD_WAIT: begin
                    if (i_mem_ack) begin
                        r_valid[w_ridx] <= 1'b1;
                        r_resp          <= extract(i_mem_rdata, r_addr[1:0], r_ctrl);
                        r_mem_req       <= 1'b0;
                        r_mem_we        <= 1'b0;
                        r_mem_be        <= 4'b0000;
                    end
                end
                S_WR_WAIT: begin
                    if (i_mem_ack) begin
                        r_resp    <= '0;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_be  <= 4'b0000;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: fills on read ack, byte merge on a store that hits.
    always_ff @(posedge clk) begin
        // NOTE: tag/data arrays carry no reset; the reset valid bits make their contents irrelevant.
        if (w_fill) begin
            r_tags[w_ridx] <= w_rtag;
            r_data[w_ridx] <= i_mem_rdata;
        end else if (w_merge) begin
            r_data[w_ridx] <= w_merged;
        end
    end

    assign o_cpu_rdata = w_rdata;
    assign o_stall     = w_stall;
    assign o_misalign  = i_cpu_req & w_illegal;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;

endmodule
